// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// One Booth step per clock; signed or unsigned operands selected per transaction.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 op_signed,
    input  logic                 abort,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mr;
    logic [WIDTH:0]   qr;
    logic             q_1;
    logic             mode_signed;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH:0]   qr_step;
    logic             q1_step;
    logic [2*WIDTH-1:0] step_product;

    assign accept    = (state == IDLE) && in_valid && !abort;
    assign last_step = (cnt == CW'(1));

    always_comb begin
        acc_sum = acc;
        unique case ({qr[0], q_1})
            2'b01:   acc_sum = acc + mr;
            2'b10:   acc_sum = acc - mr;
            default: acc_sum = acc;
        endcase
    end

    // In signed mode QR is only WIDTH bits wide, so bit WIDTH stays out of the shift chain.
    always_comb begin
        acc_step = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        q1_step  = qr[0];
        if (mode_signed) begin
            qr_step      = {1'b0, acc_sum[0], qr[WIDTH-1:1]};
            step_product = {acc_step[WIDTH-1:0], qr_step[WIDTH-1:0]};
        end else begin
            qr_step      = {acc_sum[0], qr[WIDTH:1]};
            step_product = {acc_step[WIDTH-2:0], qr_step};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid)             state_next = CALC;
                CALC: if (last_step)            state_next = DONE;
                DONE: if (out_ready)            state_next = IDLE;
                default:                        state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Abort freezes the datapath; product keeps whatever it last held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            mr          <= '0;
            qr          <= '0;
            q_1         <= 1'b0;
            mode_signed <= 1'b0;
            cnt         <= '0;
            product     <= '0;
        end else if (!abort) begin
            if (accept) begin
                acc         <= '0;
                mr          <= op_signed ? {multiplicand[WIDTH-1], multiplicand}
                                         : {1'b0, multiplicand};
                qr          <= {1'b0, multiplier};
                q_1         <= 1'b0;
                mode_signed <= op_signed;
                cnt         <= op_signed ? CW'(WIDTH) : CW'(WIDTH + 1);
            end else if (state == CALC) begin
                acc <= acc_step;
                qr  <= qr_step;
                q_1 <= q1_step;
                cnt <= cnt - CW'(1);
                if (last_step) begin
                    product <= step_product;
                end
            end
        end
    end

endmodule
